dorodon_input: RTL and testbench
================================

# dorodon_input

Player-input front end for the Dorodon core. Decodes PS/2 key events from hps_io, merges them with the OR'd joystick word, applies the orientation remap, and generates a timed coin pulse from start presses. Drives the active-low 2-bit button vectors of `ladybug` (`but_*_s`), replacing the ad-hoc key logic in `emu`.

## Interface
- `COIN_LEN`, default 1_000_000: number of cycles the coin output is held asserted.
- `COIN_GAP`, default 1_000_000: minimum number of deasserted cycles after a coin pulse before the next pulse may start.

Clock and reset:
- `CLK_IN` in 1: `clk_sys`.
- `I_RESET_N` in 1: asynchronous, active-low reset.

Inputs:
- `ps2_key` in 65: hps_io key word.
  - Bit 64 toggles once per event.
  - [15:8]=F0 marks a release.
  - E0 marks an extended key.
  - [63:24]≠0 marks PRNSCR/PAUSE.
- `joy` in 16: `joystick_0|joystick_1`. Bit assignment: 0 right, 1 left, 2 down, 3 up, 4 start1, 5 start2, 6 fire, 7 bomb.
- `rotate` in 1: `status[2]`; 1 selects horizontal orientation.

Outputs:
- `o_coin_s`, `o_fire_s`, `o_bomb_s`, `o_up_s`, `o_down_s`, `o_left_s`, `o_right_s` out 2 each, active-low.
  - Bit0 is player 1.
  - Bit1 is tied to 1.
- `o_select_s` out 2, active-low. Bit0 is start1, bit1 is start2.

## Operation
**Event detect**
- `tog_q` holds the last value of `ps2_key[64]`.
- An event is accepted on a cycle where `ps2_key[64]≠tog_q` and `ps2_key[63:24]==0`.
- `armed` is 0 after reset. On the first clock after reset it sets to 1 and loads `tog_q`, without producing an event.

**Key decode**
- `pressed = (ps2_key[15:8]≠F0)`.
- On an accepted event, the matching key-state flop is loaded with `pressed`.
- Arrow keys match regardless of the E0 prefix: 75 up, 72 down, 6B left, 74 right.
- The following keys match non-extended only: 014 ctrl = fire, 029 space = bomb, 005 F1 = start1, 006 F2 = start2.
- All other codes are ignored.

**Merge and remap** (`kb` = key-state flop)
- `rotate=0`:
  - up = kb_up|joy[3]
  - down = kb_down|joy[2]
  - left = kb_left|joy[1]
  - right = kb_right|joy[0]
- `rotate=1`:
  - up = kb_left|joy[1]
  - down = kb_right|joy[0]
  - left = kb_down|joy[2]
  - right = kb_up|joy[3]
- fire = kb_fire|joy[6]; bomb = kb_bomb|joy[7].
- start1 = kb_f1|joy[4]; start2 = kb_f2|joy[5].
- All merged levels are registered into the output flops, inverted.

**Coin FSM** (states IDLE, PULSE, GAP; counter width `$clog2(max(COIN_LEN,COIN_GAP))+1`)
- Trigger is a rising edge of the registered level `start1|start2`.
- IDLE + trigger → PULSE: counter=COIN_LEN-1, `o_coin_s[0]`=0.
- PULSE: decrement; at 0 → GAP with counter=COIN_GAP-1, coin=1.
- GAP: decrement; at 0 → PULSE if `pend` is set (clears `pend`), else → IDLE.
- A trigger during PULSE or GAP sets `pend`, a one-deep latch. Further triggers are dropped.
- A trigger coinciding with the GAP→IDLE cycle counts as pending and goes straight to PULSE.

**Reset**
- All key-state flops cleared; FSM → IDLE; `pend`=0; `armed`=0.
- All outputs = 2'b11.
- Reset asserted mid-pulse releases coin immediately (asynchronous).

## Timing
- Key event: an event present before edge k updates the key flop at k; the output changes at edge k+1. Latency is 2 clocks.
- Joystick bit change: output changes after 1 clock.
- Start edge: start level registered at edge k; `o_select_s` changes at k; `o_coin_s[0]` falls at k+1.
- Coin low width is exactly COIN_LEN cycles. High gap is exactly COIN_GAP cycles.
- Sustained repeated starts give a coin period of COIN_LEN+COIN_GAP.
- Only one event per toggle. A held key produces no repeats unless hps_io re-toggles; a re-toggle with the same value is idempotent.

## Configuration
- `DORODON_KBD_EN`:
  - Defined: event detect and key decode as above.
  - Undefined: `ps2_key` is unused, all kb flops are constant 0, and only `joy` drives the outputs. The coin FSM and remap are unchanged.

## Test plan
- Reset release with `ps2_key[64]`=1 → no event; all outputs remain 2'b11.
- Toggle with code 0x0075 (press), then toggle with F0/0x75 (release), `rotate=0` → `o_up_s` goes 2'b10 two clocks after the press, then returns to 2'b11 two clocks after the release. Same sequence with `rotate=1` → `o_right_s` asserts.
- `joy[4]` held for 10 cycles, `COIN_LEN=4`, `COIN_GAP=3` → `o_select_s`=2'b10 while held; `o_coin_s`=2'b10 for exactly 4 cycles starting one cycle after select, then 2'b11.
- Three start edges inside one PULSE → exactly two pulses, separated by exactly COIN_GAP high cycles.
- Event with `ps2_key[63:24]`≠0 (PAUSE) → no output change. Code 0xE014 → fire not asserted.
- `I_RESET_N` low during PULSE → `o_coin_s` is 2'b11 immediately. After release, FSM is IDLE and no pending pulse fires.

Source files
------------

// File: rtl/dorodon_input.sv
// dorodon_input: player-input front end for the Dorodon core.
// Decodes hps_io PS/2 key events, merges them with the joystick word,
// applies the orientation remap and drives the active-low button vectors
// of the ladybug core, including a timed coin pulse raised by start presses.
// Optional feature macro: DORODON_KBD_EN (keyboard decode; joystick only when undefined).
module dorodon_input #(
    parameter int COIN_LEN = 1_000_000,
    parameter int COIN_GAP = 1_000_000
) (
    input  logic        CLK_IN,
    input  logic        I_RESET_N,
    input  logic [64:0] ps2_key,
    input  logic [15:0] joy,
    input  logic        rotate,
    output logic [1:0]  o_coin_s,
    output logic [1:0]  o_fire_s,
    output logic [1:0]  o_bomb_s,
    output logic [1:0]  o_up_s,
    output logic [1:0]  o_down_s,
    output logic [1:0]  o_left_s,
    output logic [1:0]  o_right_s,
    output logic [1:0]  o_select_s
);

    localparam int MAXC = (COIN_LEN > COIN_GAP) ? COIN_LEN : COIN_GAP;
    localparam int CW   = $clog2(MAXC) + 1;

    // key-state vector indices
    localparam int KB_UP    = 0;
    localparam int KB_DOWN  = 1;
    localparam int KB_LEFT  = 2;
    localparam int KB_RIGHT = 3;
    localparam int KB_FIRE  = 4;
    localparam int KB_BOMB  = 5;
    localparam int KB_F1    = 6;
    localparam int KB_F2    = 7;

    logic [7:0] kb;

    // only the low joystick byte carries buttons
    logic unused_joy;
    assign unused_joy = ^joy[15:8];

`ifdef DORODON_KBD_EN
    logic       tog_q;
    logic       armed_q;
    logic [7:0] kb_q;
    logic       evt;
    logic       ext;
    logic       pressed;

    // One event per toggle of bit 64; PRNSCR/PAUSE words carry extra bytes and are skipped.
    assign evt     = armed_q && (ps2_key[64] != tog_q) && (ps2_key[63:24] == 40'd0);
    // E0 sits in the prefix byte for a press, or ahead of F0 for a release
    assign ext     = (ps2_key[15:8] == 8'hE0) || (ps2_key[23:16] == 8'hE0);
    assign pressed = (ps2_key[15:8] != 8'hF0);

    // Toggle tracking and key-state flops; the first clock after reset only samples the toggle.
    always_ff @(posedge CLK_IN or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            tog_q   <= 1'b0;
            armed_q <= 1'b0;
            kb_q    <= '0;
        end else begin
            tog_q   <= ps2_key[64];
            armed_q <= 1'b1;
            if (evt) begin
                case (ps2_key[7:0])
                    8'h75: kb_q[KB_UP]    <= pressed;
                    8'h72: kb_q[KB_DOWN]  <= pressed;
                    8'h6B: kb_q[KB_LEFT]  <= pressed;
                    8'h74: kb_q[KB_RIGHT] <= pressed;
                    8'h14: if (!ext) kb_q[KB_FIRE] <= pressed;
                    8'h29: if (!ext) kb_q[KB_BOMB] <= pressed;
                    8'h05: if (!ext) kb_q[KB_F1]   <= pressed;
                    8'h06: if (!ext) kb_q[KB_F2]   <= pressed;
                    default: ;
                endcase
            end
        end
    end

    assign kb = kb_q;
`else
    logic unused_ps2;
    assign unused_ps2 = ^ps2_key;
    assign kb         = '0;
`endif

    // merged (active-high) levels
    logic up, down, left, right, fire, bomb, start1, start2;

    // Keyboard/joystick merge with the horizontal-orientation remap.
    always_comb begin
        up     = kb[KB_UP]    | joy[3];
        down   = kb[KB_DOWN]  | joy[2];
        left   = kb[KB_LEFT]  | joy[1];
        right  = kb[KB_RIGHT] | joy[0];
        if (rotate) begin
            up    = kb[KB_LEFT]  | joy[1];
            down  = kb[KB_RIGHT] | joy[0];
            left  = kb[KB_DOWN]  | joy[2];
            right = kb[KB_UP]    | joy[3];
        end
        fire   = kb[KB_FIRE] | joy[6];
        bomb   = kb[KB_BOMB] | joy[7];
        start1 = kb[KB_F1]   | joy[4];
        start2 = kb[KB_F2]   | joy[5];
    end

    logic       up_n_q, down_n_q, left_n_q, right_n_q, fire_n_q, bomb_n_q;
    logic [1:0] sel_n_q;
    logic       start_q, start_prev_q;

    // Register the merged levels inverted, plus the start level and its delayed copy for edge detect.
    always_ff @(posedge CLK_IN or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            up_n_q       <= 1'b1;
            down_n_q     <= 1'b1;
            left_n_q     <= 1'b1;
            right_n_q    <= 1'b1;
            fire_n_q     <= 1'b1;
            bomb_n_q     <= 1'b1;
            sel_n_q      <= 2'b11;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            up_n_q       <= ~up;
            down_n_q     <= ~down;
            left_n_q     <= ~left;
            right_n_q    <= ~right;
            fire_n_q     <= ~fire;
            bomb_n_q     <= ~bomb;
            sel_n_q      <= ~{start2, start1};
            start_q      <= start1 | start2;
            start_prev_q <= start_q;
        end
    end

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          trig;

    assign trig = start_q & ~start_prev_q;

    // Coin FSM state register; async reset drops any pulse in flight.
    always_ff @(posedge CLK_IN or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Coin sequencing: LEN cycles low, GAP cycles high, one trigger remembered across a busy period.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = PULSE;
                    cnt_d   = CW'(COIN_LEN - 1);
                end
            end
            PULSE: begin
                if (trig) pend_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = CW'(COIN_GAP - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    // a trigger on the exit cycle is treated as already pending
                    if (pend_q || trig) begin
                        state_d = PULSE;
                        cnt_d   = CW'(COIN_LEN - 1);
                        pend_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (trig) pend_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    assign o_coin_s   = {1'b1, (state_q != PULSE)};
    assign o_select_s = sel_n_q;
    assign o_up_s     = {1'b1, up_n_q};
    assign o_down_s   = {1'b1, down_n_q};
    assign o_left_s   = {1'b1, left_n_q};
    assign o_right_s  = {1'b1, right_n_q};
    assign o_fire_s   = {1'b1, fire_n_q};
    assign o_bomb_s   = {1'b1, bomb_n_q};

endmodule

// File: tb/tb_dorodon_input.sv
// Bench for dorodon_input: directed per-cycle vectors; the driver queues the
// hand-computed expected outputs, a monitor pops and compares after each edge.
module tb_dorodon_input;

`ifdef DORODON_KBD_EN
    localparam bit KBD = 1'b1;
`else
    localparam bit KBD = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [64:0] ps2_key;
    logic [15:0] joy;
    logic        rotate;
    logic [1:0]  o_coin_s, o_fire_s, o_bomb_s, o_up_s, o_down_s, o_left_s, o_right_s, o_select_s;

    dorodon_input #(.COIN_LEN(4), .COIN_GAP(3)) dut (
        .CLK_IN     (clk),
        .I_RESET_N  (rst_n),
        .ps2_key    (ps2_key),
        .joy        (joy),
        .rotate     (rotate),
        .o_coin_s   (o_coin_s),
        .o_fire_s   (o_fire_s),
        .o_bomb_s   (o_bomb_s),
        .o_up_s     (o_up_s),
        .o_down_s   (o_down_s),
        .o_left_s   (o_left_s),
        .o_right_s  (o_right_s),
        .o_select_s (o_select_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [8:0] e;   // {coin, sel2, sel1, up, down, left, right, fire, bomb}, active low
    } exp_t;

    exp_t exp_q[$];
    exp_t async_q[$];
    int   rid = 0;
    bit   done = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    localparam logic [8:0] I = 9'h1FF;

    function automatic logic [8:0] K(input logic [8:0] x);
        return KBD ? x : I;
    endfunction

    function automatic logic [15:0] expand(input logic [8:0] e);
        return {1'b1, e[8], e[7], e[6], 1'b1, e[5], 1'b1, e[4], 1'b1, e[3],
                1'b1, e[2], 1'b1, e[1], 1'b1, e[0]};
    endfunction

    // one cycle of stimulus; e is the output expected after the next clock edge
    task automatic row(input logic rst, input logic tg, input logic [63:0] kd,
                       input logic [7:0] j, input logic rot, input logic [8:0] e);
        exp_t x;
        @(posedge clk);
        #2;
        rst_n   = rst;
        ps2_key = {tg, kd};
        joy     = {8'h00, j};
        rotate  = rot;
        x.id = rid;
        x.e  = e;
        exp_q.push_back(x);
        if (!rst) async_q.push_back(x);
        rid++;
    endtask

    // monitor: all comparisons and the summary live here
    initial begin : monitor
        exp_t       x;
        logic [15:0] act;
        do begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x   = exp_q.pop_front();
                act = {o_coin_s, o_select_s, o_up_s, o_down_s, o_left_s, o_right_s, o_fire_s, o_bomb_s};
                n_checks++;
                if (act !== expand(x.e)) begin
                    n_fail++;
                    $display("FAIL row%0d: outputs got %h expected %h", x.id, act, expand(x.e));
                end
            end
            @(negedge clk);
            if (async_q.size() > 0) begin
                x   = async_q.pop_front();
                act = {o_coin_s, o_select_s, o_up_s, o_down_s, o_left_s, o_right_s, o_fire_s, o_bomb_s};
                n_checks++;
                if (act !== expand(x.e)) begin
                    n_fail++;
                    $display("FAIL async_reset row%0d: outputs got %h expected %h", x.id, act, expand(x.e));
                end
            end
        end while (!done);
        n_checks++;
        if (exp_q.size() != 0 || async_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: queued got %0d expected 0", exp_q.size() + async_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        clk     = 1'b0;
        rst_n   = 1'b0;
        ps2_key = {1'b1, 64'd0};
        joy     = '0;
        rotate  = 1'b0;

        // reset held, released with toggle bit high: no event
        row(0, 1, 64'h0, 8'h00, 0, I);
        row(0, 1, 64'h0, 8'h00, 0, I);
        row(1, 1, 64'h0, 8'h00, 0, I);
        row(1, 1, 64'h0, 8'h00, 0, I);
        row(1, 1, 64'h0, 8'h00, 0, I);
        // up press / release, rotate=0: two-clock latency
        row(1, 0, 64'h0075, 8'h00, 0, I);
        row(1, 0, 64'h0075, 8'h00, 0, K(9'h1DF));
        row(1, 0, 64'h0075, 8'h00, 0, K(9'h1DF));
        row(1, 1, 64'hF075, 8'h00, 0, K(9'h1DF));
        row(1, 1, 64'hF075, 8'h00, 0, I);
        // same with rotate=1: appears on right
        row(1, 0, 64'h0075, 8'h00, 1, I);
        row(1, 0, 64'h0075, 8'h00, 1, K(9'h1FB));
        row(1, 1, 64'hF075, 8'h00, 1, K(9'h1FB));
        row(1, 1, 64'hF075, 8'h00, 1, I);
        // ctrl = fire
        row(1, 0, 64'h0014, 8'h00, 0, I);
        row(1, 0, 64'h0014, 8'h00, 0, K(9'h1FD));
        row(1, 1, 64'hF014, 8'h00, 0, K(9'h1FD));
        row(1, 1, 64'hF014, 8'h00, 0, I);
        // extended E014 is not fire
        row(1, 0, 64'hE014, 8'h00, 0, I);
        row(1, 0, 64'hE014, 8'h00, 0, I);
        // PAUSE-style word is ignored; no re-toggle afterwards means no event
        row(1, 1, 64'h1_0000_0075, 8'h00, 0, I);
        row(1, 1, 64'h1_0000_0075, 8'h00, 0, I);
        row(1, 1, 64'h0075, 8'h00, 0, I);
        row(1, 1, 64'h0075, 8'h00, 0, I);
        // extended arrow press / extended release still match
        row(1, 0, 64'hE075, 8'h00, 0, I);
        row(1, 0, 64'hE075, 8'h00, 0, K(9'h1DF));
        row(1, 1, 64'hE0F075, 8'h00, 0, K(9'h1DF));
        row(1, 1, 64'hE0F075, 8'h00, 0, I);
        // joystick, one-clock latency, with remap
        row(1, 1, 64'h0, 8'h08, 0, 9'h1DF);
        row(1, 1, 64'h0, 8'h08, 1, 9'h1FB);
        row(1, 1, 64'h0, 8'h01, 0, 9'h1FB);
        row(1, 1, 64'h0, 8'h02, 1, 9'h1DF);
        row(1, 1, 64'h0, 8'hC0, 0, 9'h1FC);
        row(1, 1, 64'h0, 8'h00, 0, I);
        // start1 held 10 cycles: select low, coin low 4 cycles one after select
        row(1, 1, 64'h0, 8'h10, 0, 9'h1BF);
        repeat (4) row(1, 1, 64'h0, 8'h10, 0, 9'h0BF);
        repeat (5) row(1, 1, 64'h0, 8'h10, 0, 9'h1BF);
        row(1, 1, 64'h0, 8'h00, 0, I);
        // three start edges in one pulse: two pulses, gap of 3
        row(1, 1, 64'h0, 8'h10, 0, 9'h1BF);
        row(1, 1, 64'h0, 8'h00, 0, 9'h0FF);
        row(1, 1, 64'h0, 8'h10, 0, 9'h0BF);
        row(1, 1, 64'h0, 8'h00, 0, 9'h0FF);
        row(1, 1, 64'h0, 8'h10, 0, 9'h0BF);
        repeat (3) row(1, 1, 64'h0, 8'h00, 0, I);
        repeat (4) row(1, 1, 64'h0, 8'h00, 0, 9'h0FF);
        repeat (6) row(1, 1, 64'h0, 8'h00, 0, I);
        // reset in the middle of a pulse with a pending trigger
        row(1, 1, 64'h0, 8'h10, 0, 9'h1BF);
        row(1, 1, 64'h0, 8'h00, 0, 9'h0FF);
        row(1, 1, 64'h0, 8'h10, 0, 9'h0BF);
        row(1, 1, 64'h0, 8'h00, 0, 9'h0FF);
        row(0, 1, 64'h0, 8'h00, 0, I);
        row(0, 1, 64'h0, 8'h00, 0, I);
        repeat (9) row(1, 1, 64'h0, 8'h00, 0, I);

        repeat (2) @(posedge clk);
        done = 1;
    end

endmodule
